// File: rtl/dram_req_if.sv
// -----------------------------------------------------------------------------
// dram_req_if
// Bundles the request/response handshake and the DRAM command bus between a
// requester, dram_req_ctrl and the single-bank DRAM model.
//   slave  : controller side (accepts requests, drives DRAM commands)
//   master : requester / DRAM side (drives requests and DRAM read returns)
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata : request channel
//   resp_valid/resp_rdata                            : one-cycle read return
//   rd_err                                           : sticky missing-valid flag
//   dram_cmd/dram_row/dram_col/dram_wr_data          : DRAM command bus
//   dram_rd_data/dram_valid                          : DRAM read return
// -----------------------------------------------------------------------------
interface dram_req_if #(
   parameter int ROW_W  = 6,
   parameter int COL_W  = 5,
   parameter int DATA_W = 8
) ();
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [ROW_W+COL_W-1:0]  req_addr;
   logic [DATA_W-1:0]       req_wdata;
   logic                    resp_valid;
   logic [DATA_W-1:0]       resp_rdata;
   logic                    rd_err;
   logic [1:0]              dram_cmd;
   logic [ROW_W-1:0]        dram_row;
   logic [COL_W-1:0]        dram_col;
   logic [DATA_W-1:0]       dram_wr_data;
   logic [DATA_W-1:0]       dram_rd_data;
   logic                    dram_valid;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, dram_rd_data, dram_valid,
      output req_ready, resp_valid, resp_rdata, rd_err,
             dram_cmd, dram_row, dram_col, dram_wr_data
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, dram_rd_data, dram_valid,
      input  req_ready, resp_valid, resp_rdata, rd_err,
             dram_cmd, dram_row, dram_col, dram_wr_data
   );
endinterface

// File: rtl/dram_req_ctrl.sv
// -----------------------------------------------------------------------------
// dram_req_ctrl
// Open-page request controller in front of a single-bank DRAM. One request is
// in flight at a time; the address splits into {row, col}. The controller
// issues PRE/ACT as needed, then READ or WRITE, and returns read data as a
// single-cycle resp_valid pulse. An open row is auto-precharged after
// IDLE_CLOSE idle cycles (0 disables this).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (assert together with the DRAM reset)
//   bus  : dram_req_if.slave -- request channel, response, rd_err, DRAM bus
// All bus outputs are registered. The DRAM has no NOP, so idle cycles drive a
// WRITE to a row that is not open, which the DRAM ignores.
// -----------------------------------------------------------------------------
module dram_req_ctrl #(
   parameter int ROW_W      = 6,
   parameter int COL_W      = 5,
   parameter int DATA_W     = 8,
   parameter int IDLE_CLOSE = 16
) (
   input  logic      clk,
   input  logic      rst,
   dram_req_if.slave bus
);

   localparam int CNT_W = (IDLE_CLOSE < 1) ? 1 : $clog2(IDLE_CLOSE + 1);

   localparam logic [1:0] CMD_ACT = 2'b00;
   localparam logic [1:0] CMD_RD  = 2'b01;
   localparam logic [1:0] CMD_WR  = 2'b10;
   localparam logic [1:0] CMD_PRE = 2'b11;

   // Each state name is the command on the DRAM bus while in that state.
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PRE      = 3'd1,
      S_ACT      = 3'd2,
      S_ACCESS   = 3'd3,
      S_RD_WAIT  = 3'd4,
      S_RD_CAP   = 3'd5,
      S_AUTO_PRE = 3'd6
   } state_t;

   state_t              state_q;
   logic                row_open_q;
   logic [ROW_W-1:0]    open_row_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                lat_write_q;
   logic [ROW_W-1:0]    lat_row_q;
   logic [COL_W-1:0]    lat_col_q;
   logic [DATA_W-1:0]   lat_wdata_q;
   logic                resp_valid_q;
   logic [DATA_W-1:0]   resp_rdata_q;
   logic                rd_err_q;
   logic [1:0]          dram_cmd_q;
   logic [ROW_W-1:0]    dram_row_q;
   logic [COL_W-1:0]    dram_col_q;
   logic [DATA_W-1:0]   dram_wr_data_q;

   logic                accept_s;
   logic [ROW_W-1:0]    req_row_s;
   logic [COL_W-1:0]    req_col_s;
   logic                row_hit_s;
   logic [CNT_W-1:0]    cnt_d;
   logic                cnt_expire_s;

   // Request decode and idle-counter next value.
   always_comb begin
      accept_s  = bus.req_valid && (state_q == S_IDLE);
      req_row_s = bus.req_addr[ROW_W+COL_W-1:COL_W];
      req_col_s = bus.req_addr[COL_W-1:0];
      row_hit_s = row_open_q && (req_row_s == open_row_q);
      cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (IDLE_CLOSE != 0) begin
         cnt_expire_s = (cnt_d == CNT_W'(IDLE_CLOSE));
      end else begin
         cnt_expire_s = 1'b0;
      end
   end

   // Controller FSM: state, open-row tracking, and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         row_open_q     <= 1'b0;
         open_row_q     <= {ROW_W{1'b0}};
         cnt_q          <= {CNT_W{1'b0}};
         lat_write_q    <= 1'b0;
         lat_row_q      <= {ROW_W{1'b0}};
         lat_col_q      <= {COL_W{1'b0}};
         lat_wdata_q    <= {DATA_W{1'b0}};
         resp_valid_q   <= 1'b0;
         resp_rdata_q   <= {DATA_W{1'b0}};
         rd_err_q       <= 1'b0;
         dram_cmd_q     <= CMD_WR;
         dram_row_q     <= {{(ROW_W-1){1'b0}}, 1'b1};
         dram_col_q     <= {COL_W{1'b0}};
         dram_wr_data_q <= {DATA_W{1'b0}};
      end else begin
         // Idle no-op: WRITE to a row that is guaranteed not to be open.
         dram_cmd_q     <= CMD_WR;
         dram_row_q     <= open_row_q ^ {{(ROW_W-1){1'b0}}, 1'b1};
         dram_col_q     <= {COL_W{1'b0}};
         dram_wr_data_q <= {DATA_W{1'b0}};
         resp_valid_q   <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (accept_s) begin
                  lat_write_q <= bus.req_write;
                  lat_row_q   <= req_row_s;
                  lat_col_q   <= req_col_s;
                  lat_wdata_q <= bus.req_wdata;
                  cnt_q       <= {CNT_W{1'b0}};
                  if (row_hit_s) begin
                     // Page hit: column command goes out next cycle directly.
                     state_q        <= S_ACCESS;
                     dram_cmd_q     <= bus.req_write ? CMD_WR : CMD_RD;
                     dram_row_q     <= req_row_s;
                     dram_col_q     <= req_col_s;
                     dram_wr_data_q <= bus.req_wdata;
                  end else if (row_open_q) begin
                     state_q    <= S_PRE;
                     dram_cmd_q <= CMD_PRE;
                     dram_row_q <= open_row_q;
                     row_open_q <= 1'b0;
                  end else begin
                     state_q    <= S_ACT;
                     dram_cmd_q <= CMD_ACT;
                     dram_row_q <= req_row_s;
                     row_open_q <= 1'b1;
                     open_row_q <= req_row_s;
                  end
               end else if (row_open_q) begin
                  // An accept in the expiry cycle takes the branch above.
                  if (cnt_expire_s) begin
                     state_q    <= S_AUTO_PRE;
                     dram_cmd_q <= CMD_PRE;
                     dram_row_q <= open_row_q;
                     row_open_q <= 1'b0;
                     cnt_q      <= {CNT_W{1'b0}};
                  end else if (IDLE_CLOSE != 0) begin
                     cnt_q <= cnt_d;
                  end else begin
                     cnt_q <= {CNT_W{1'b0}};
                  end
               end else begin
                  cnt_q <= {CNT_W{1'b0}};
               end
            end

            S_PRE: begin
               state_q    <= S_ACT;
               dram_cmd_q <= CMD_ACT;
               dram_row_q <= lat_row_q;
               row_open_q <= 1'b1;
               open_row_q <= lat_row_q;
            end

            S_ACT: begin
               state_q        <= S_ACCESS;
               dram_cmd_q     <= lat_write_q ? CMD_WR : CMD_RD;
               dram_row_q     <= lat_row_q;
               dram_col_q     <= lat_col_q;
               dram_wr_data_q <= lat_wdata_q;
            end

            S_ACCESS: begin
               state_q <= lat_write_q ? S_IDLE : S_RD_WAIT;
            end

            S_RD_WAIT: begin
               // The DRAM strobes valid one cycle after READ.
               if (!bus.dram_valid) begin
                  rd_err_q <= 1'b1;
               end else begin
                  rd_err_q <= rd_err_q;
               end
               state_q <= S_RD_CAP;
            end

            S_RD_CAP: begin
               resp_valid_q <= 1'b1;
               resp_rdata_q <= bus.dram_rd_data;
               state_q      <= S_IDLE;
            end

            S_AUTO_PRE: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q    <= S_IDLE;
               row_open_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready    = (state_q == S_IDLE);
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_rdata   = resp_rdata_q;
   assign bus.rd_err       = rd_err_q;
   assign bus.dram_cmd     = dram_cmd_q;
   assign bus.dram_row     = dram_row_q;
   assign bus.dram_col     = dram_col_q;
   assign bus.dram_wr_data = dram_wr_data_q;

endmodule

// File: tb/tb_dram_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dram_req_ctrl
// Drives dram_req_ctrl against a small single-bank DRAM model. Expected read
// data is pushed to a queue when a read is issued and popped when resp_valid
// pulses. Command latencies and first commands come from a vector table;
// auto-precharge, missing dram_valid and mid-read reset are hand sequences.
// -----------------------------------------------------------------------------
module tb_dram_req_ctrl;
   localparam int ROW_W = 6, COL_W = 5, DATA_W = 8, IDLE_CLOSE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dram_req_if #(.ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W)) bus ();

   dram_req_ctrl #(.ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W),
                   .IDLE_CLOSE(IDLE_CLOSE)) dut (.clk(clk), .rst(rst), .bus(bus));

   // ---------------- DRAM model ----------------
   logic [7:0] mem [0:2047];
   logic       m_open;
   logic [5:0] m_row;
   logic       m_vld;
   logic [7:0] m_buf, m_rd;
   logic       drop_valid = 1'b0;
   int         model_err = 0;

   assign bus.dram_valid   = m_vld & ~drop_valid;
   assign bus.dram_rd_data = m_rd;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_open <= 1'b0; m_row <= 6'd0; m_vld <= 1'b0; m_buf <= 8'd0; m_rd <= 8'd0;
      end else begin
         m_vld <= 1'b0;
         m_rd  <= m_buf;
         case (bus.dram_cmd)
            2'b00: begin
               if (m_open) model_err <= model_err + 1;
               m_open <= 1'b1; m_row <= bus.dram_row;
            end
            2'b01: begin
               if (!m_open || m_row != bus.dram_row) model_err <= model_err + 1;
               m_vld <= 1'b1;
               m_buf <= mem[{bus.dram_row, bus.dram_col}];
            end
            2'b10: begin
               if (m_open && m_row == bus.dram_row)
                  mem[{bus.dram_row, bus.dram_col}] <= bus.dram_wr_data;
            end
            default: m_open <= 1'b0;
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q [$];
   logic [7:0] ref_mem [0:2047];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.resp_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_resp got=%0h exp=none", bus.resp_rdata);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (bus.resp_rdata !== e) begin
               bad++;
               $display("FAIL resp_data got=%0h exp=%0h", bus.resp_rdata, e);
            end
         end
      end
   end

   // ---------------- request driver ----------------
   logic [1:0] log_cmd [0:15];
   logic [5:0] log_row [0:15];
   logic [4:0] log_col [0:15];
   logic [7:0] log_dat [0:15];
   int   r_lat;
   logic r_rv;

   // Enter at a negedge; returns at the negedge where req_ready is high again.
   task automatic run_req(input logic wr, input logic [5:0] row, input logic [4:0] col,
                          input logic [7:0] wd);
      int n;
      n = 0;
      while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
      if (!bus.req_ready) begin
         total++; bad++;
         $display("FAIL ready_timeout got=0 exp=1");
      end
      bus.req_valid = 1'b1; bus.req_write = wr;
      bus.req_addr  = {row, col}; bus.req_wdata = wd;
      if (wr) ref_mem[{row, col}] = wd;
      else    exp_q.push_back(ref_mem[{row, col}]);
      @(negedge clk);
      bus.req_valid = 1'b0;
      r_lat = 0; r_rv = 1'b0;
      for (int k = 1; k < 16; k++) begin
         log_cmd[k] = bus.dram_cmd; log_row[k] = bus.dram_row;
         log_col[k] = bus.dram_col; log_dat[k] = bus.dram_wr_data;
         if (bus.req_ready) begin r_lat = k; r_rv = bus.resp_valid; break; end
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic       wr;
      logic [5:0] row;
      logic [4:0] col;
      logic [7:0] wd;
      logic [1:0] cmd1;
      int         lat;
   } vec_t;

   vec_t vt [10];

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   pre_cnt, pre_at;
      logic rdy_at_pre;
      logic [1:0] cmd_after;
      logic [5:0] row_after;

      vt[0] = '{1'b0, 6'd3,  5'd7,  8'h00, 2'b01, 4};
      vt[1] = '{1'b1, 6'd9,  5'd0,  8'h3C, 2'b11, 4};
      vt[2] = '{1'b0, 6'd9,  5'd0,  8'h00, 2'b01, 4};
      vt[3] = '{1'b1, 6'd9,  5'd31, 8'h5A, 2'b10, 2};
      vt[4] = '{1'b0, 6'd9,  5'd31, 8'h00, 2'b01, 4};
      vt[5] = '{1'b0, 6'd3,  5'd7,  8'h00, 2'b11, 6};
      vt[6] = '{1'b1, 6'd63, 5'd31, 8'hFF, 2'b11, 4};
      vt[7] = '{1'b0, 6'd63, 5'd31, 8'h00, 2'b01, 4};
      vt[8] = '{1'b1, 6'd0,  5'd0,  8'h81, 2'b11, 4};
      vt[9] = '{1'b0, 6'd0,  5'd0,  8'h00, 2'b01, 4};

      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = 8'd0;
      repeat (2) @(negedge clk);
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_rdata", bus.resp_rdata, 0);
      chk("rst_rd_err", bus.rd_err, 0);
      chk("rst_cmd", bus.dram_cmd, 2'b10);
      chk("rst_row", bus.dram_row, 1);
      chk("rst_col", bus.dram_col, 0);
      chk("rst_wdata", bus.dram_wr_data, 0);
      rst = 1'b0;
      @(negedge clk);

      // First write: row closed, ACT then WRITE.
      run_req(1'b1, 6'd3, 5'd7, 8'hA5);
      chk("w0_c1_cmd", log_cmd[1], 2'b00);
      chk("w0_c1_row", log_row[1], 3);
      chk("w0_c2_cmd", log_cmd[2], 2'b10);
      chk("w0_c2_row", log_row[2], 3);
      chk("w0_c2_col", log_col[2], 7);
      chk("w0_c2_dat", log_dat[2], 8'hA5);
      chk("w0_lat", r_lat, 3);
      chk("w0_no_resp", r_rv, 0);

      for (int i = 0; i < 10; i++) begin
         run_req(vt[i].wr, vt[i].row, vt[i].col, vt[i].wd);
         chk($sformatf("v%0d_cmd1", i), log_cmd[1], vt[i].cmd1);
         chk($sformatf("v%0d_lat", i), r_lat, vt[i].lat);
         chk($sformatf("v%0d_resp_at_ready", i), r_rv, vt[i].wr ? 0 : 1);
         if (vt[i].cmd1 == 2'b11) begin
            chk($sformatf("v%0d_act", i), log_cmd[2], 2'b00);
            chk($sformatf("v%0d_act_row", i), log_row[2], vt[i].row);
         end
         if (!vt[i].wr && vt[i].cmd1 == 2'b01)
            chk($sformatf("v%0d_nop_row", i), log_row[2], vt[i].row ^ 6'd1);
      end

      // Auto-precharge: conflict write, WRITE in cycle 3, then stay idle.
      run_req(1'b1, 6'd5, 5'd2, 8'h42);
      chk("ap_w_lat", r_lat, 4);
      pre_cnt = 0; pre_at = 0; rdy_at_pre = 1'b1; cmd_after = 2'b00; row_after = 6'd5;
      for (int j = 5; j <= 16; j++) begin
         @(negedge clk);
         if (pre_at != 0 && j == pre_at + 1) begin
            cmd_after = bus.dram_cmd; row_after = bus.dram_row;
         end
         if (bus.dram_cmd == 2'b11) begin
            pre_cnt++; pre_at = j; rdy_at_pre = bus.req_ready;
         end
      end
      chk("ap_pre_count", pre_cnt, 1);
      chk("ap_pre_cycle", pre_at, 3 + IDLE_CLOSE + 1);
      chk("ap_ready_low", rdy_at_pre, 0);
      chk("ap_after_cmd", cmd_after, 2'b10);
      chk("ap_after_row_not_open", (row_after != 6'd5), 1);
      run_req(1'b0, 6'd5, 5'd2, 8'h00);
      chk("ap_rd_cmd1", log_cmd[1], 2'b00);
      chk("ap_rd_lat", r_lat, 5);

      // Missing dram_valid: sticky rd_err, response still pulses.
      chk("err_before", bus.rd_err, 0);
      drop_valid = 1'b1;
      run_req(1'b0, 6'd5, 5'd2, 8'h00);
      drop_valid = 1'b0;
      chk("err_lat", r_lat, 4);
      chk("err_resp", r_rv, 1);
      chk("err_set", bus.rd_err, 1);
      run_req(1'b0, 6'd5, 5'd2, 8'h00);
      chk("err_sticky", bus.rd_err, 1);

      // Reset while the read is in RD_WAIT; no response may follow.
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = {6'd5, 5'd2};
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", bus.req_ready, 1);
      chk("mid_rst_resp", bus.resp_valid, 0);
      chk("mid_rst_err", bus.rd_err, 0);
      chk("mid_rst_cmd", bus.dram_cmd, 2'b10);
      chk("mid_rst_row", bus.dram_row, 1);
      chk("mid_rst_col", bus.dram_col, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      run_req(1'b0, 6'd5, 5'd2, 8'h00);
      chk("post_rst_cmd1", log_cmd[1], 2'b00);
      chk("post_rst_lat", r_lat, 5);

      repeat (2) @(negedge clk);
      chk("dram_protocol_errors", model_err, 0);
      chk("pending_reads", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
